// File: rtl/icache_responder_if.sv
// Fetch-side and memory-side signals of the instruction cache, bundled for port use.
// slave is the cache's view; master is the fetch stage plus memory controller.
interface icache_responder_if;
   logic        iREN;
   logic [31:0] iaddr;
   logic        flush;
   logic        ihit;
   logic [31:0] iload;
   logic        mem_iREN;
   logic [31:0] mem_iaddr;
   logic        mem_iwait;
   logic [31:0] mem_iload;

   modport slave (
      input  iREN, iaddr, flush,
      output ihit, iload,
      output mem_iREN, mem_iaddr,
      input  mem_iwait, mem_iload
   );

   modport master (
      output iREN, iaddr, flush,
      input  ihit, iload,
      input  mem_iREN, mem_iaddr,
      output mem_iwait, mem_iload
   );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-line instruction cache between fetch and the memory arbiter.
// Define ICACHE_STATS_EN to add the hit_count/miss_count statistics ports.
module icache_responder #(
   parameter int SETS          = 16,
   parameter int MISS_WAIT_MAX = 0
) (
   input  logic               CLK,
   input  logic               RST,
   icache_responder_if.slave  bus,
   output logic               timeout
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0]        hit_count,
   output logic [31:0]        miss_count
`endif
);

   localparam int IDX  = $clog2(SETS);
   localparam int TAGW = 30 - IDX;

   typedef enum logic [1:0] {IDLE, MISS, FILL} state_t;

   state_t          state, next_state;
   logic [SETS-1:0] valid;
   logic [TAGW-1:0] tag_mem  [SETS];
   logic [31:0]     data_mem [SETS];
   logic [29:0]     miss_word;
   logic [IDX-1:0]  idx, miss_idx;
   logic [TAGW-1:0] tag, miss_tag;
   logic            lookup_hit;
   logic            fill_en;
   logic            unused_byte_offset;

   assign idx        = bus.iaddr[IDX+1:2];
   assign tag        = bus.iaddr[31:IDX+2];
   assign miss_idx   = miss_word[IDX-1:0];
   assign miss_tag   = miss_word[29:IDX];
   assign lookup_hit = valid[idx] && (tag_mem[idx] == tag);
   assign unused_byte_offset = ^bus.iaddr[1:0];

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         valid     <= '0;
         miss_word <= '0;
      end else begin
         state <= next_state;
         if (bus.flush)
            valid <= '0;
         else if (fill_en)
            valid[miss_idx] <= 1'b1;
         if (state == IDLE && next_state == MISS)
            miss_word <= bus.iaddr[31:2];
      end
   end

   // Tag/data storage needs no reset: a line is only ever read behind its valid bit.
   always_ff @(posedge CLK) begin
      if (fill_en && !RST) begin
         tag_mem[miss_idx]  <= miss_tag;
         data_mem[miss_idx] <= bus.mem_iload;
      end
   end

   always_comb begin
      next_state    = state;
      bus.ihit      = 1'b0;
      bus.iload     = '0;
      bus.mem_iREN  = 1'b0;
      bus.mem_iaddr = '0;
      fill_en       = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.flush) begin
               next_state = IDLE;
            end else if (bus.iREN && lookup_hit) begin
               bus.ihit  = 1'b1;
               bus.iload = data_mem[idx];
            end else if (bus.iREN) begin
               next_state = MISS;
            end
         end
         MISS: begin
            bus.mem_iREN  = 1'b1;
            bus.mem_iaddr = {miss_word, 2'b00};
            // A flush aborts the read even when the data arrives in the same cycle.
            if (bus.flush) begin
               next_state = IDLE;
            end else if (!bus.mem_iwait) begin
               fill_en    = 1'b1;
               next_state = FILL;
            end
         end
         FILL: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   generate
      if (MISS_WAIT_MAX > 0) begin : g_watchdog
         logic [31:0] wait_cnt;
         logic        timeout_q;

         // Counts stalled miss cycles and saturates; the flag sticks until reset.
         always_ff @(posedge CLK) begin
            if (RST) begin
               wait_cnt  <= '0;
               timeout_q <= 1'b0;
            end else if (state == MISS && bus.mem_iwait) begin
               if (wait_cnt < 32'(MISS_WAIT_MAX))
                  wait_cnt <= wait_cnt + 32'd1;
               if (wait_cnt >= 32'(MISS_WAIT_MAX - 1))
                  timeout_q <= 1'b1;
            end else if (state != MISS) begin
               wait_cnt <= '0;
            end
         end

         assign timeout = timeout_q;
      end else begin : g_no_watchdog
         assign timeout = 1'b0;
      end
   endgenerate

`ifdef ICACHE_STATS_EN
   always_ff @(posedge CLK) begin
      if (RST) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (bus.ihit)
            hit_count <= hit_count + 32'd1;
         if (state == IDLE && next_state == MISS)
            miss_count <= miss_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder: randomized fetches against a line-level cache model.
// Stats checks are compiled in when ICACHE_STATS_EN is defined.
module tb_icache_responder;

   localparam int SETS = 16;
   localparam int WD   = 4;

   logic CLK = 1'b0;
   logic RST;
   logic timeout;
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   icache_responder_if bus();

   icache_responder #(.SETS(SETS), .MISS_WAIT_MAX(WD)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .bus        (bus.slave),
      .timeout    (timeout)
`ifdef ICACHE_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;

   // Reference model: which word address each line holds, and its data.
   bit          model_valid [SETS];
   logic [29:0] model_word  [SETS];
   logic [31:0] model_data  [SETS];
   logic [31:0] mem_img [logic [29:0]];
   bit          exp_timeout;
   int          exp_hits;
   int          exp_misses;

   function automatic logic [31:0] mem_word(input logic [29:0] w);
      if (mem_img.exists(w)) return mem_img[w];
      return {w[15:0], w[29:14]} ^ 32'h5A5A_C3C3;
   endfunction

   function automatic int idx_of(input logic [31:0] a);
      return int'((a >> 2) & 32'(SETS - 1));
   endfunction

   function automatic bit model_hit(input logic [31:0] a);
      int i;
      i = idx_of(a);
      return model_valid[i] && (model_word[i] == a[31:2]);
   endfunction

   task automatic model_clear();
      foreach (model_valid[i]) model_valid[i] = 1'b0;
   endtask

   task automatic idle_cycle();
      @(negedge CLK);
      bus.iREN      = 1'b0;
      bus.flush     = 1'b0;
      bus.mem_iwait = 1'b1;
   endtask

   // One complete fetch of addr; on a miss memory answers after 'waits' busy cycles.
   task automatic do_fetch(input logic [31:0] addr, input int waits, input string name);
      int i;
      bit exp_to;
      i = idx_of(addr);
      @(negedge CLK);
      bus.iREN      = 1'b1;
      bus.iaddr     = addr;
      bus.flush     = 1'b0;
      bus.mem_iwait = 1'b1;
      #1;
      checks++;
      if (model_hit(addr)) begin
         if (bus.ihit !== 1'b1 || bus.iload !== model_data[i] || bus.mem_iREN !== 1'b0 || timeout !== exp_timeout) begin
            errors++;
            $display("[TB] FAIL %s hit: ihit=%0b iload=%h mem_iREN=%0b timeout=%0b, expected ihit=1 iload=%h mem_iREN=0 timeout=%0b",
                     name, bus.ihit, bus.iload, bus.mem_iREN, timeout, model_data[i], exp_timeout);
         end
         exp_hits++;
      end else begin
         if (bus.ihit !== 1'b0 || bus.iload !== 32'h0) begin
            errors++;
            $display("[TB] FAIL %s lookup: ihit=%0b iload=%h, expected ihit=0 iload=0", name, bus.ihit, bus.iload);
         end
         exp_misses++;
         for (int k = 0; k <= waits; k++) begin
            @(negedge CLK);
            bus.mem_iwait = (k < waits);
            bus.mem_iload = (k == waits) ? mem_word(addr[31:2]) : $urandom();
            #1;
            exp_to = exp_timeout || (k >= WD);
            checks++;
            if (bus.mem_iREN !== 1'b1 || bus.mem_iaddr !== {addr[31:2], 2'b00} || bus.ihit !== 1'b0 || timeout !== exp_to) begin
               errors++;
               $display("[TB] FAIL %s miss cycle %0d: mem_iREN=%0b mem_iaddr=%h ihit=%0b timeout=%0b, expected 1 %h 0 %0b",
                        name, k, bus.mem_iREN, bus.mem_iaddr, bus.ihit, timeout, {addr[31:2], 2'b00}, exp_to);
            end
         end
         if (waits >= WD) exp_timeout = 1'b1;
         model_valid[i] = 1'b1;
         model_word[i]  = addr[31:2];
         model_data[i]  = mem_word(addr[31:2]);
         @(negedge CLK);
         bus.mem_iwait = 1'b1;
         bus.mem_iload = $urandom();
         #1;
         checks++;
         if (bus.mem_iREN !== 1'b0 || bus.ihit !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s fill bubble: mem_iREN=%0b ihit=%0b, expected 0 0", name, bus.mem_iREN, bus.ihit);
         end
         @(negedge CLK);
         #1;
         checks++;
         if (bus.ihit !== 1'b1 || bus.iload !== model_data[i] || timeout !== exp_timeout) begin
            errors++;
            $display("[TB] FAIL %s refill hit: ihit=%0b iload=%h timeout=%0b, expected 1 %h %0b",
                     name, bus.ihit, bus.iload, timeout, model_data[i], exp_timeout);
         end
         exp_hits++;
      end
   endtask

   task automatic test_reset();
      RST           = 1'b1;
      bus.iREN      = 1'b0;
      bus.iaddr     = '0;
      bus.flush     = 1'b0;
      bus.mem_iwait = 1'b1;
      bus.mem_iload = '0;
      repeat (2) @(negedge CLK);
      #1;
      checks++;
      if (bus.ihit !== 1'b0 || bus.iload !== 32'h0 || bus.mem_iREN !== 1'b0 || bus.mem_iaddr !== 32'h0 || timeout !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset outputs: ihit=%0b iload=%h mem_iREN=%0b mem_iaddr=%h timeout=%0b, expected all 0",
                  bus.ihit, bus.iload, bus.mem_iREN, bus.mem_iaddr, timeout);
      end
      @(negedge CLK);
      RST = 1'b0;
      model_clear();
      exp_timeout = 1'b0;
      exp_hits    = 0;
      exp_misses  = 0;
   endtask

   task automatic test_first_miss();
      mem_img[30'(32'h40 >> 2)] = 32'h8C01_0004;
      do_fetch(32'h0000_0040, 3, "first_miss");
   endtask

   task automatic test_sequential();
      do_fetch(32'h0, 1, "warm0");
      do_fetch(32'h4, 0, "warm4");
      do_fetch(32'h8, 2, "warm8");
      do_fetch(32'h0, 0, "seq0");
      do_fetch(32'h4, 0, "seq4");
      do_fetch(32'h8, 0, "seq8");
   endtask

   task automatic test_conflict();
      mem_img[30'(32'h10 >> 2)] = 32'h1111_AAAA;
      mem_img[30'(32'h50 >> 2)] = 32'h2222_BBBB;
      do_fetch(32'h10, 1, "conflict_a");
      do_fetch(32'h50, 2, "conflict_b");
      do_fetch(32'h10, 0, "conflict_a_again");
   endtask

   task automatic test_flush_idle();
      do_fetch(32'h30, 0, "flush_idle_warm");
      @(negedge CLK);
      bus.iREN  = 1'b1;
      bus.iaddr = 32'h30;
      bus.flush = 1'b1;
      #1;
      checks++;
      if (bus.ihit !== 1'b0 || bus.iload !== 32'h0) begin
         errors++;
         $display("[TB] FAIL flush_idle ihit: ihit=%0b iload=%h, expected 0 0", bus.ihit, bus.iload);
      end
      model_clear();
      do_fetch(32'h30, 1, "flush_idle_refetch");
   endtask

   task automatic test_flush_in_miss();
      logic [31:0] addrs [2];
      addrs[0] = 32'h20;
      addrs[1] = 32'h24;
      do_fetch(32'h0, 0, "flush_miss_warm0");
      for (int n = 0; n < 2; n++) begin
         @(negedge CLK);
         bus.iREN  = 1'b1;
         bus.iaddr = addrs[n];
         #1;
         exp_misses++;
         @(negedge CLK);
         bus.flush     = 1'b1;
         bus.mem_iwait = (n == 0);
         bus.mem_iload = $urandom();
         #1;
         checks++;
         if (bus.mem_iREN !== 1'b1 || bus.mem_iaddr !== addrs[n]) begin
            errors++;
            $display("[TB] FAIL flush_miss%0d request: mem_iREN=%0b mem_iaddr=%h, expected 1 %h", n, bus.mem_iREN, bus.mem_iaddr, addrs[n]);
         end
         @(negedge CLK);
         bus.flush     = 1'b0;
         bus.iREN      = 1'b0;
         bus.mem_iwait = 1'b1;
         #1;
         checks++;
         if (bus.mem_iREN !== 1'b0 || bus.ihit !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_miss%0d abort: mem_iREN=%0b ihit=%0b, expected 0 0", n, bus.mem_iREN, bus.ihit);
         end
         model_clear();
      end
      do_fetch(32'h20, 1, "flush_miss_refetch20");
      do_fetch(32'h24, 0, "flush_miss_refetch24");
      do_fetch(32'h0, 0, "flush_miss_refetch0");
   endtask

   task automatic test_random();
      logic [31:0] a;
      for (int n = 0; n < 40; n++) begin
         a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
         do_fetch(a, int'($urandom_range(0, 3)), "random");
      end
   endtask

   task automatic test_watchdog();
      do_fetch(32'h200, 6, "watchdog_miss");
      do_fetch(32'h200, 0, "watchdog_hit");
      do_fetch(32'h204, 0, "watchdog_sticky");
   endtask

   task automatic test_reset_mid_miss();
      @(negedge CLK);
      bus.iREN  = 1'b1;
      bus.iaddr = 32'h7C4;
      #1;
      @(negedge CLK);
      RST      = 1'b1;
      bus.iREN = 1'b0;
      #1;
      checks++;
      if (bus.mem_iREN !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_mid_miss pre: mem_iREN=%0b, expected 1", bus.mem_iREN);
      end
      @(negedge CLK);
      RST = 1'b0;
      #1;
      checks++;
      if (bus.mem_iREN !== 1'b0 || bus.ihit !== 1'b0 || bus.mem_iaddr !== 32'h0 || timeout !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_mid_miss post: mem_iREN=%0b ihit=%0b mem_iaddr=%h timeout=%0b, expected 0 0 0 0",
                  bus.mem_iREN, bus.ihit, bus.mem_iaddr, timeout);
      end
      model_clear();
      exp_timeout = 1'b0;
      exp_hits    = 0;
      exp_misses  = 0;
      do_fetch(32'h7C4, 1, "reset_mid_miss_refetch");
   endtask

`ifdef ICACHE_STATS_EN
   task automatic test_stats();
      @(negedge CLK);
      RST      = 1'b1;
      bus.iREN = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      model_clear();
      exp_timeout = 1'b0;
      exp_hits    = 0;
      exp_misses  = 0;
      do_fetch(32'h100, 1, "stats_miss0");
      do_fetch(32'h104, 0, "stats_miss1");
      do_fetch(32'h100, 0, "stats_hit0");
      do_fetch(32'h104, 0, "stats_hit1");
      do_fetch(32'h100, 0, "stats_hit2");
      idle_cycle();
      #1;
      checks++;
      if (hit_count !== 32'(exp_hits) || miss_count !== 32'(exp_misses)) begin
         errors++;
         $display("[TB] FAIL stats: hit_count=%0d miss_count=%0d, expected %0d %0d", hit_count, miss_count, exp_hits, exp_misses);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_first_miss();
      test_sequential();
      test_conflict();
      test_flush_idle();
      test_flush_in_miss();
      test_random();
      test_watchdog();
      test_reset_mid_miss();
`ifdef ICACHE_STATS_EN
      test_stats();
`endif
      idle_cycle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
